// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard_if
//  Description : Read, write, LO/HI, issue and status bus of the register
//                file scoreboard.
//  Revision    : 1.0
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 3
);
  logic [NREAD*ADDR_W-1:0] rdAddr;
  logic [NREAD*2-1:0]      rdSel;
  logic [NREAD*DATA_W-1:0] rdData;
  logic [NREAD-1:0]        rdBusy;

  logic                    wrEnA;
  logic [ADDR_W-1:0]       wrAddrA;
  logic [DATA_W-1:0]       wrDataA;
  logic                    wrEnB;
  logic [ADDR_W-1:0]       wrAddrB;
  logic [DATA_W-1:0]       wrDataB;

  logic                    wrLoHi;
  logic [DATA_W-1:0]       loData;
  logic [DATA_W-1:0]       hiData;

  logic                    issueEn;
  logic [ADDR_W-1:0]       issueAddr;
  logic                    issueLoHi;
  logic                    flush;

  logic [ADDR_W:0]         pendingCount;
  logic                    loHiBusy;

  modport master (
    output rdAddr, rdSel, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB,
           wrLoHi, loData, hiData, issueEn, issueAddr, issueLoHi, flush,
    input  rdData, rdBusy, pendingCount, loHiBusy
  );

  modport slave (
    input  rdAddr, rdSel, wrEnA, wrAddrA, wrDataA, wrEnB, wrAddrB, wrDataB,
           wrLoHi, loData, hiData, issueEn, issueAddr, issueLoHi, flush,
    output rdData, rdBusy, pendingCount, loHiBusy
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Multi-port GPR file with write bypass, HI/LO pair and a
//                per-register pending scoreboard for issue hazard detection.
//  Revision    : 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NREAD    = 3,
  parameter int ZERO_REG = 1
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam int c_DEPTH = 2**ADDR_W;
  localparam int c_CNT_W = ADDR_W + 1;

  logic [DATA_W-1:0]      r_gpr [c_DEPTH];
  logic [DATA_W-1:0]      r_lo;
  logic [DATA_W-1:0]      r_hi;
  logic [c_DEPTH-1:0]     r_pending;
  logic [c_CNT_W-1:0]     r_pend_cnt;
  logic                   r_lohi_busy;

  logic [c_DEPTH-1:0]     w_wr_a_hit;
  logic [c_DEPTH-1:0]     w_wr_b_hit;
  logic [c_DEPTH-1:0]     w_issue_hit;
  logic [c_DEPTH-1:0]     w_pending_nxt;
  logic [c_CNT_W-1:0]     w_pend_cnt_nxt;
  logic                   w_lohi_busy_nxt;
  logic [NREAD*DATA_W-1:0] w_rd_flat;
  logic [NREAD-1:0]       w_rd_busy;

  // Hit vectors exclude the hardwired zero register, so it is never written or marked pending.
  always_comb begin
    w_wr_a_hit  = '0;
    w_wr_b_hit  = '0;
    w_issue_hit = '0;
    for (int r = 0; r < c_DEPTH; r++) begin
      if (!(ZERO_REG != 0 && r == 0)) begin
        w_wr_a_hit[r]  = bus.wrEnA   && (bus.wrAddrA   == ADDR_W'(r));
        w_wr_b_hit[r]  = bus.wrEnB   && (bus.wrAddrB   == ADDR_W'(r));
        w_issue_hit[r] = bus.issueEn && (bus.issueAddr == ADDR_W'(r));
      end
    end
  end

  // Issue outranks writeback: the newly issued producer is younger than the one retiring.
  always_comb begin
    w_pending_nxt  = r_pending;
    w_pend_cnt_nxt = '0;
    for (int r = 0; r < c_DEPTH; r++) begin
      if (bus.flush)
        w_pending_nxt[r] = 1'b0;
      else if (w_issue_hit[r])
        w_pending_nxt[r] = 1'b1;
      else if (w_wr_a_hit[r] || w_wr_b_hit[r])
        w_pending_nxt[r] = 1'b0;
      w_pend_cnt_nxt = w_pend_cnt_nxt + c_CNT_W'(w_pending_nxt[r]);
    end
  end

  always_comb begin
    w_lohi_busy_nxt = r_lohi_busy;
    if (bus.flush)
      w_lohi_busy_nxt = 1'b0;
    else if (bus.issueLoHi)
      w_lohi_busy_nxt = 1'b1;
    else if (bus.wrLoHi)
      w_lohi_busy_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < c_DEPTH; r++)
        r_gpr[r] <= '0;
      r_lo        <= '0;
      r_hi        <= '0;
      r_pending   <= '0;
      r_pend_cnt  <= '0;
      r_lohi_busy <= 1'b0;
    end else begin
      for (int r = 0; r < c_DEPTH; r++) begin
        if (w_wr_b_hit[r])
          r_gpr[r] <= bus.wrDataB;
        else if (w_wr_a_hit[r])
          r_gpr[r] <= bus.wrDataA;
      end
      if (bus.wrLoHi) begin
        r_lo <= bus.loData;
        r_hi <= bus.hiData;
      end
      r_pending   <= w_pending_nxt;
      r_pend_cnt  <= w_pend_cnt_nxt;
      r_lohi_busy <= w_lohi_busy_nxt;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    logic [1:0]        w_sel;
    logic              w_zero;
    logic              w_written;
    logic [DATA_W-1:0] w_gpr;
    logic [DATA_W-1:0] w_data;
    logic              w_busy;

    assign w_addr    = bus.rdAddr[g*ADDR_W +: ADDR_W];
    assign w_sel     = bus.rdSel[g*2 +: 2];
    assign w_zero    = (ZERO_REG != 0) && (w_addr == '0);
    assign w_written = w_wr_a_hit[w_addr] || w_wr_b_hit[w_addr];

    always_comb begin
      w_gpr = r_gpr[w_addr];
      if (w_wr_b_hit[w_addr])
        w_gpr = bus.wrDataB;
      else if (w_wr_a_hit[w_addr])
        w_gpr = bus.wrDataA;
      if (w_zero)
        w_gpr = '0;
    end

    always_comb begin
      w_data = '0;
      w_busy = 1'b0;
      case (w_sel)
        2'b00: begin
          w_data = w_gpr;
          w_busy = r_pending[w_addr] && !w_written && !w_zero;
        end
        2'b01: begin
          w_data = bus.wrLoHi ? bus.loData : r_lo;
          w_busy = r_lohi_busy && !bus.wrLoHi;
        end
        2'b10: begin
          w_data = bus.wrLoHi ? bus.hiData : r_hi;
          w_busy = r_lohi_busy && !bus.wrLoHi;
        end
        default: begin
          w_data = '0;
          w_busy = 1'b0;
        end
      endcase
    end

    assign w_rd_flat[g*DATA_W +: DATA_W] = w_data;
    assign w_rd_busy[g]                  = w_busy;
  end

  assign bus.rdData       = w_rd_flat;
  assign bus.rdBusy       = w_rd_busy;
  assign bus.pendingCount = r_pend_cnt;
  assign bus.loHiBusy     = r_lohi_busy;
endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_scoreboard
//  Description : Directed and random stimulus against a behavioural model of
//                the register file scoreboard.
//  Revision    : 1.0
// ============================================================================
module tb_regfile_scoreboard;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREAD  = 3;
  localparam int DEPTH  = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD)) bus ();

  regfile_scoreboard #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREAD(NREAD), .ZERO_REG(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] m_gpr [DEPTH];
  logic [DATA_W-1:0] m_lo, m_hi;
  bit                m_pend [DEPTH];
  bit                m_lohi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int a = 0; a < DEPTH; a++) begin
      m_gpr[a]  = '0;
      m_pend[a] = 1'b0;
    end
    m_lo   = '0;
    m_hi   = '0;
    m_lohi = 1'b0;
  endtask

  task automatic idle();
    bus.rdAddr = '0; bus.rdSel = '0;
    bus.wrEnA = 0; bus.wrAddrA = '0; bus.wrDataA = '0;
    bus.wrEnB = 0; bus.wrAddrB = '0; bus.wrDataB = '0;
    bus.wrLoHi = 0; bus.loData = '0; bus.hiData = '0;
    bus.issueEn = 0; bus.issueAddr = '0; bus.issueLoHi = 0; bus.flush = 0;
  endtask

  task automatic set_rd(input int p, input int addr, input int sel);
    bus.rdAddr[p*ADDR_W +: ADDR_W] = ADDR_W'(addr);
    bus.rdSel[p*2 +: 2]            = 2'(sel);
  endtask

  function automatic bit written(input int a);
    return (a != 0) && ((bus.wrEnA && int'(bus.wrAddrA) == a) ||
                        (bus.wrEnB && int'(bus.wrAddrB) == a));
  endfunction

  // Value register a holds once the current edge has committed; bypass must show exactly this.
  function automatic logic [DATA_W-1:0] post_gpr(input int a);
    logic [DATA_W-1:0] v;
    if (a == 0) return '0;
    v = m_gpr[a];
    if (bus.wrEnA && int'(bus.wrAddrA) == a) v = bus.wrDataA;
    if (bus.wrEnB && int'(bus.wrAddrB) == a) v = bus.wrDataB;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int p);
    int a = int'(bus.rdAddr[p*ADDR_W +: ADDR_W]);
    case (int'(bus.rdSel[p*2 +: 2]))
      0:       return post_gpr(a);
      1:       return bus.wrLoHi ? bus.loData : m_lo;
      2:       return bus.wrLoHi ? bus.hiData : m_hi;
      default: return '0;
    endcase
  endfunction

  function automatic bit exp_busy(input int p);
    int a = int'(bus.rdAddr[p*ADDR_W +: ADDR_W]);
    case (int'(bus.rdSel[p*2 +: 2]))
      0:       return (a != 0) && m_pend[a] && !written(a);
      1, 2:    return m_lohi && !bus.wrLoHi;
      default: return 1'b0;
    endcase
  endfunction

  function automatic int model_count();
    int n = 0;
    for (int a = 0; a < DEPTH; a++) n += int'(m_pend[a]);
    return n;
  endfunction

  // Inputs are already driven (after a falling edge); check reads, clock, update model, check status.
  task automatic step();
    #1;
    for (int p = 0; p < NREAD; p++) begin
      chk($sformatf("rdData[%0d]", p), 64'(bus.rdData[p*DATA_W +: DATA_W]), 64'(exp_data(p)));
      chk($sformatf("rdBusy[%0d]", p), 64'(bus.rdBusy[p]), 64'(exp_busy(p)));
    end
    @(posedge clk);
    for (int a = 0; a < DEPTH; a++) begin
      bit wr = written(a);
      m_gpr[a] = post_gpr(a);
      if (wr) m_pend[a] = 1'b0;
      if (bus.issueEn && int'(bus.issueAddr) == a && a != 0) m_pend[a] = 1'b1;
      if (bus.flush) m_pend[a] = 1'b0;
    end
    if (bus.wrLoHi) begin
      m_lo   = bus.loData;
      m_hi   = bus.hiData;
      m_lohi = 1'b0;
    end
    if (bus.issueLoHi) m_lohi = 1'b1;
    if (bus.flush)     m_lohi = 1'b0;
    #1;
    chk("pendingCount", 64'(bus.pendingCount), 64'(model_count()));
    chk("loHiBusy", 64'(bus.loHiBusy), 64'(m_lohi));
    @(negedge clk);
  endtask

  task automatic drive_random();
    for (int p = 0; p < NREAD; p++)
      set_rd(p, $urandom_range(0, 7), $urandom_range(0, 3));
    bus.wrEnA     = ($urandom_range(0, 1) == 0);
    bus.wrAddrA   = ADDR_W'($urandom_range(0, 7));
    bus.wrDataA   = $urandom;
    bus.wrEnB     = ($urandom_range(0, 2) == 0);
    bus.wrAddrB   = ADDR_W'($urandom_range(0, 7));
    bus.wrDataB   = $urandom;
    bus.wrLoHi    = ($urandom_range(0, 3) == 0);
    bus.loData    = $urandom;
    bus.hiData    = $urandom;
    bus.issueEn   = ($urandom_range(0, 4) < 2);
    bus.issueAddr = ADDR_W'($urandom_range(0, 7));
    bus.issueLoHi = ($urandom_range(0, 4) == 0);
    bus.flush     = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_count", 64'(bus.pendingCount), 64'd0);
    chk("rst_lohi", 64'(bus.loHiBusy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset state through all read ports.
    set_rd(0, 1, 0); set_rd(1, 2, 0); set_rd(2, 3, 0);
    step();

    // Single-port write bypass, then array readback.
    idle();
    bus.wrEnA = 1; bus.wrAddrA = 5; bus.wrDataA = 32'hDEADBEEF;
    set_rd(0, 5, 0);
    #1 chk("bypassA", 64'(bus.rdData[DATA_W-1:0]), 64'hDEADBEEF);
    step();
    idle(); set_rd(0, 5, 0);
    #1 chk("arrayA", 64'(bus.rdData[DATA_W-1:0]), 64'hDEADBEEF);
    step();

    // Both ports to the same address: B wins.
    idle();
    bus.wrEnA = 1; bus.wrAddrA = 7; bus.wrDataA = 32'h11;
    bus.wrEnB = 1; bus.wrAddrB = 7; bus.wrDataB = 32'h22;
    set_rd(1, 7, 0);
    #1 chk("bypassAB", 64'(bus.rdData[DATA_W +: DATA_W]), 64'h22);
    step();
    idle(); set_rd(1, 7, 0);
    #1 chk("arrayAB", 64'(bus.rdData[DATA_W +: DATA_W]), 64'h22);
    step();

    // Scoreboard set / clear by writeback / issue beats writeback.
    idle(); bus.issueEn = 1; bus.issueAddr = 9; step();
    idle(); set_rd(0, 9, 0);
    #1 chk("busy9", 64'(bus.rdBusy[0]), 64'd1);
    chk("count9", 64'(bus.pendingCount), 64'd1);
    step();
    idle(); set_rd(0, 9, 0); bus.wrEnB = 1; bus.wrAddrB = 9; bus.wrDataB = 32'h99;
    #1 chk("busy9_wb", 64'(bus.rdBusy[0]), 64'd0);
    step();
    chk("count9_wb", 64'(bus.pendingCount), 64'd0);
    idle(); bus.issueEn = 1; bus.issueAddr = 9; bus.wrEnA = 1; bus.wrAddrA = 9; bus.wrDataA = 32'h5;
    step();
    chk("count9_iw", 64'(bus.pendingCount), 64'd1);

    // Zero register and HI/LO.
    idle(); bus.wrEnA = 1; bus.wrAddrA = 0; bus.wrDataA = 32'hFFFF;
    bus.issueEn = 1; bus.issueAddr = 0; set_rd(0, 0, 0);
    #1 chk("zero_byp", 64'(bus.rdData[DATA_W-1:0]), 64'd0);
    step();
    chk("zero_cnt", 64'(bus.pendingCount), 64'd1);
    idle(); bus.issueLoHi = 1; step();
    idle(); bus.wrLoHi = 1; bus.loData = 32'h1; bus.hiData = 32'h2;
    set_rd(0, 0, 1); set_rd(1, 0, 2); set_rd(2, 0, 3);
    step();
    idle(); set_rd(0, 0, 1); set_rd(1, 0, 2);
    #1 chk("lo", 64'(bus.rdData[DATA_W-1:0]), 64'h1);
    chk("hi", 64'(bus.rdData[DATA_W +: DATA_W]), 64'h2);
    step();

    // Flush wins over a same-cycle issue.
    for (int a = 1; a <= 4; a++) begin
      idle(); bus.issueEn = 1; bus.issueAddr = ADDR_W'(a); step();
    end
    idle(); bus.flush = 1; bus.issueEn = 1; bus.issueAddr = 6; step();
    chk("flush_cnt", 64'(bus.pendingCount), 64'd0);

    // Randomised traffic.
    for (int c = 0; c < 400; c++) begin
      drive_random();
      step();
    end

    // Asynchronous reset in the middle of a low phase.
    idle();
    bus.issueEn = 1; bus.issueAddr = 3; bus.issueLoHi = 1;
    bus.wrEnA = 1; bus.wrAddrA = 3; bus.wrDataA = 32'hA5A5;
    step();
    idle(); set_rd(0, 3, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cnt", 64'(bus.pendingCount), 64'd0);
    chk("arst_lohi", 64'(bus.loHiBusy), 64'd0);
    chk("arst_data", 64'(bus.rdData[DATA_W-1:0]), 64'd0);
    chk("arst_busy", 64'(bus.rdBusy[0]), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_rd(0, 3, 0);
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
